// File: rtl/alu_seq_if.sv
// Request/response and ALU-port bundle between the decode stage, alu_seq and the ALU.
// master = requester plus ALU side, slave = the sequencer.
interface alu_seq_if #(
    parameter int BITS  = 32,
    parameter int CBITS = 4
) ();
    logic             IN_VALID;
    logic             IN_READY;
    logic [3:0]       FUNC;
    logic [BITS-1:0]  OPA;
    logic [BITS-1:0]  OPB;
    logic [BITS-1:0]  ALU_A;
    logic [BITS-1:0]  ALU_B;
    logic [CBITS-1:0] ALU_CTL;
    logic [BITS-1:0]  ALU_OUT;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [BITS-1:0]  RESULT;
    logic             ERR;

    modport master (
        output IN_VALID, FUNC, OPA, OPB, OUT_READY, ALU_OUT,
        input  IN_READY, ALU_A, ALU_B, ALU_CTL, OUT_VALID, RESULT, ERR
    );

    modport slave (
        input  IN_VALID, FUNC, OPA, OPB, OUT_READY, ALU_OUT,
        output IN_READY, ALU_A, ALU_B, ALU_CTL, OUT_VALID, RESULT, ERR
    );
endinterface

// File: rtl/alu_seq.sv
// Sequencing front-end for the combinational ALU: single-cycle ops, shift-add
// multiply through the ALU adder, and a held result with valid/ready output.
module alu_seq #(
    parameter int BITS  = 32,
    parameter int CBITS = 4
) (
    input logic     CLK,
    input logic     RESET,
    alu_seq_if.slave bus
);
    localparam logic [CBITS-1:0] CMD_ADD  = CBITS'(4'b0000);
    localparam logic [CBITS-1:0] CMD_SUB  = CBITS'(4'b0001);
    localparam logic [CBITS-1:0] CMD_LT   = CBITS'(4'b0101);
    localparam logic [CBITS-1:0] CMD_AND  = CBITS'(4'b1000);
    localparam logic [CBITS-1:0] CMD_OR   = CBITS'(4'b1001);
    localparam logic [CBITS-1:0] CMD_XOR  = CBITS'(4'b1010);
    localparam logic [CBITS-1:0] CMD_NAND = CBITS'(4'b1011);
    localparam logic [CBITS-1:0] CMD_NOR  = CBITS'(4'b1100);
    localparam logic [CBITS-1:0] CMD_NXOR = CBITS'(4'b1101);

    localparam logic [3:0] F_LE   = 4'd3;
    localparam logic [3:0] F_NXOR = 4'd9;
    localparam logic [3:0] F_MUL  = 4'd10;

    localparam int            CW        = $clog2(BITS);
    localparam logic [CW-1:0] LAST_ITER = CW'(BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_func;
    logic [BITS-1:0]  r_opa;
    logic [BITS-1:0]  r_opb;
    logic [BITS-1:0]  r_acc;
    logic [BITS-1:0]  r_mcand;
    logic [BITS-1:0]  r_mplier;
    logic [CW-1:0]    r_cnt;
    logic [BITS-1:0]  r_result;
    logic             r_err;

    logic [BITS-1:0]  w_aluA;
    logic [BITS-1:0]  w_aluB;
    logic [CBITS-1:0] w_aluCtl;
    logic [CBITS-1:0] w_cmd;
    logic [BITS-1:0]  w_accNext;

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.IN_VALID) begin
                if (bus.FUNC <= F_NXOR)     w_next = S_EXEC;
                else if (bus.FUNC == F_MUL) w_next = S_MUL;
                else                        w_next = S_DONE;
            end
            S_EXEC: w_next = S_DONE;
            S_MUL:  if (r_cnt == LAST_ITER) w_next = S_DONE;
            S_DONE: if (bus.OUT_READY) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_func)
            4'd0:    w_cmd = CMD_ADD;
            4'd1:    w_cmd = CMD_SUB;
            4'd2:    w_cmd = CMD_LT;
            4'd3:    w_cmd = CMD_LT;
            4'd4:    w_cmd = CMD_AND;
            4'd5:    w_cmd = CMD_OR;
            4'd6:    w_cmd = CMD_XOR;
            4'd7:    w_cmd = CMD_NAND;
            4'd8:    w_cmd = CMD_NOR;
            4'd9:    w_cmd = CMD_NXOR;
            default: w_cmd = CMD_ADD;
        endcase
    end

    // LE is computed as !(B < A), so the operands are swapped onto the ALU.
    always_comb begin
        w_aluA   = '0;
        w_aluB   = '0;
        w_aluCtl = CMD_ADD;
        case (r_state)
            S_EXEC: begin
                w_aluA   = (r_func == F_LE) ? r_opb : r_opa;
                w_aluB   = (r_func == F_LE) ? r_opa : r_opb;
                w_aluCtl = w_cmd;
            end
            S_MUL: begin
                w_aluA   = r_acc;
                w_aluB   = r_mcand;
                w_aluCtl = CMD_ADD;
            end
            default: ;
        endcase
    end

    assign bus.IN_READY  = (r_state == S_IDLE);
    assign bus.OUT_VALID = (r_state == S_DONE);
    assign bus.ALU_A     = w_aluA;
    assign bus.ALU_B     = w_aluB;
    assign bus.ALU_CTL   = w_aluCtl;
    assign bus.RESULT    = r_result;
    assign bus.ERR       = r_err;

    assign w_accNext = r_mplier[0] ? bus.ALU_OUT : r_acc;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_func   <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.IN_VALID) begin
                    r_func <= bus.FUNC;
                    r_opa  <= bus.OPA;
                    r_opb  <= bus.OPB;
                    if (bus.FUNC == F_MUL) begin
                        r_acc    <= '0;
                        r_mcand  <= bus.OPA;
                        r_mplier <= bus.OPB;
                        r_cnt    <= '0;
                    end else if (bus.FUNC > F_MUL) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_result <= (r_func == F_LE) ? {{(BITS-1){1'b0}}, ~bus.ALU_OUT[0]} : bus.ALU_OUT;
                    r_err    <= 1'b0;
                end
                S_MUL: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_result <= w_accNext;
                        r_err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops against a
// plain-arithmetic reference model, with a behavioural ALU on the ALU ports.
module tb_alu_seq;
    localparam int BITS = 32;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;
    int   lastWait = 0;

    always #5 CLK = ~CLK;

    alu_seq_if #(.BITS(BITS), .CBITS(4)) bus ();

    alu_seq #(.BITS(BITS), .CBITS(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Stand-in for the combinational ALU the sequencer drives.
    function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl);
        case (ctl)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0101: return {31'b0, $signed(a) < $signed(b)};
            4'b1000: return a & b;
            4'b1001: return a | b;
            4'b1010: return a ^ b;
            4'b1011: return ~(a & b);
            4'b1100: return ~(a | b);
            4'b1101: return ~(a ^ b);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb bus.ALU_OUT = aluModel(bus.ALU_A, bus.ALU_B, bus.ALU_CTL);

    function automatic void refModel(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic e);
        e = 1'b0;
        case (f)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = {31'b0, $signed(a) <  $signed(b)};
            4'd3:  r = {31'b0, $signed(a) <= $signed(b)};
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = ~(a & b);
            4'd8:  r = ~(a | b);
            4'd9:  r = ~(a ^ b);
            4'd10: r = a * b;
            default: begin
                r = 32'd0;
                e = 1'b1;
            end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] func, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (bus.IN_READY !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        lastWait = n;
        checkOutput("accept_ready", {31'b0, bus.IN_READY}, 32'd1);
        bus.IN_VALID = 1'b1;
        bus.FUNC     = func;
        bus.OPA      = a;
        bus.OPB      = b;
        @(posedge CLK);
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        bus.FUNC     = 4'($urandom);
        bus.OPA      = $urandom;
        bus.OPB      = $urandom;
    endtask

    task automatic runOp(input string tag, input logic [3:0] func, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input logic expErr, input int hold);
        int edges = 0;
        int expLat;
        bit ctlBad = 0;
        bit holdBad = 0;
        expLat = (func == 4'd10) ? BITS + 1 : (func > 4'd10) ? 1 : 2;
        applyStimulus(func, a, b);
        checkOutput({tag, "_busy"}, {31'b0, bus.IN_READY}, 32'd0);
        while (bus.OUT_VALID !== 1'b1 && edges < 200) begin
            if (func == 4'd10 && bus.ALU_CTL !== 4'b0000) ctlBad = 1;
            @(negedge CLK);
            edges++;
        end
        checkOutput({tag, "_latency"}, 32'(edges + 1), 32'(expLat));
        if (func == 4'd10) checkOutput({tag, "_mulctl"}, {31'b0, ctlBad}, 32'd0);
        checkOutput({tag, "_result"}, bus.RESULT, expRes);
        checkOutput({tag, "_err"}, {31'b0, bus.ERR}, {31'b0, expErr});
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            if (bus.RESULT !== expRes || bus.ERR !== expErr || bus.IN_READY !== 1'b0 || bus.OUT_VALID !== 1'b1)
                holdBad = 1;
        end
        if (hold > 0) checkOutput({tag, "_hold"}, {31'b0, holdBad}, 32'd0);
        bus.OUT_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.OUT_READY = 1'b0;
        checkOutput({tag, "_release"}, {30'b0, bus.IN_READY, bus.OUT_VALID}, 32'b10);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        RESET         = 1'b1;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        bus.FUNC      = 4'd0;
        bus.OPA       = 32'd0;
        bus.OPB       = 32'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        checkOutput("rst_ready", {31'b0, bus.IN_READY}, 32'd1);
        checkOutput("rst_valid", {31'b0, bus.OUT_VALID}, 32'd0);
        checkOutput("rst_result", bus.RESULT, 32'd0);
        checkOutput("rst_err", {31'b0, bus.ERR}, 32'd0);
        checkOutput("rst_alu", {bus.ALU_A[13:0], bus.ALU_B[13:0], bus.ALU_CTL}, 32'd0);

        runOp("add", 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 0);
        runOp("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
        runOp("lt_m1_1", 4'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0);
        runOp("lt_1_m1", 4'd2, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        runOp("le_3_3", 4'd3, 32'd3, 32'd3, 32'd1, 1'b0, 0);
        runOp("le_4_3", 4'd3, 32'd4, 32'd3, 32'd0, 1'b0, 0);
        runOp("le_min_max", 4'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, 0);
        runOp("nand", 4'd7, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF0F_EDCB, 1'b0, 0);
        runOp("mul_7_6", 4'd10, 32'd7, 32'd6, 32'd42, 1'b0, 0);
        runOp("mul_ff_2", 4'd10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 0);
        runOp("mul_m3_5", 4'd10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 0);
        runOp("illegal", 4'd15, 32'd9, 32'd9, 32'd0, 1'b1, 0);
        runOp("add_after_err", 4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 0);

        runOp("backpressure", 4'd6, 32'hAAAA_5555, 32'h0F0F_0F0F, 32'hA5A5_5A5A, 1'b0, 10);
        runOp("back_to_back", 4'd5, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 0);
        checkOutput("b2b_wait", 32'(lastWait), 32'd0);

        applyStimulus(4'd10, 32'd7, 32'd9);
        repeat (9) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        checkOutput("midmul_rst_ready", {31'b0, bus.IN_READY}, 32'd1);
        checkOutput("midmul_rst_valid", {31'b0, bus.OUT_VALID}, 32'd0);
        checkOutput("midmul_rst_result", bus.RESULT, 32'd0);
        runOp("mul_2_3", 4'd10, 32'd2, 32'd3, 32'd6, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            f = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if (i % 8 == 0) a = {{28{a[31]}}, a[3:0]};
            refModel(f, a, b, r, e);
            runOp("rand", f, a, b, r, e, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
